// File: rtl/checking_empty.sv
// checking_empty: read-domain control of the async FIFO. It synchronises the write gray pointer and owns the read pointers.
// It also produces empty, fill level and almost-empty. Optional sticky underflow flag: define RD_UNDERFLOW_EN.
module checking_empty #(
  parameter int Addr      = 3,
  parameter int SYNC_STG  = 2,
  parameter int AE_THRESH = 1
) (
  input  logic          rdclk,
  input  logic          rst,
  input  logic          rdreq,
  input  logic [Addr:0] wrptr_in,
  output logic [Addr:0] rdptr,
  output logic [Addr:0] rdaddr,
  output logic          empty_reg,
  output logic [Addr:0] rd_level,
  output logic          almost_empty,
  output logic          underflow
);

  localparam logic [Addr:0] AE_LVL = (Addr+1)'(AE_THRESH);

  logic [Addr:0] sync_q [SYNC_STG];
  logic [Addr:0] sync_d [SYNC_STG];
  logic [Addr:0] rdaddr_q, rdaddr_d;
  logic [Addr:0] rdptr_q, rdptr_d;
  logic [Addr:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;

  logic [Addr:0] wrptr_s;
  logic [Addr:0] wbin;
  logic          rd_en;

  always_comb begin
    sync_d[0] = wrptr_in;
    for (int i = 1; i < SYNC_STG; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wrptr_s = sync_q[SYNC_STG-1];

  always_comb begin
    wbin       = '0;
    wbin[Addr] = wrptr_s[Addr];
    for (int i = Addr - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ wrptr_s[i];
    end
  end

  // Flags are computed from the post-update pointer so the last read raises empty on its own edge.
  always_comb begin
    rd_en    = rdreq & ~empty_q;
    rdaddr_d = rdaddr_q + (Addr+1)'(rd_en);
    rdptr_d  = (rdaddr_d >> 1) ^ rdaddr_d;
    empty_d  = (rdptr_d == wrptr_s);
    level_d  = wbin - rdaddr_d;
    ae_d     = (level_d <= AE_LVL);
  end

  always_ff @(posedge rdclk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STG; i++) begin
        sync_q[i] <= '0;
      end
      rdaddr_q <= '0;
      rdptr_q  <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
    end else begin
      for (int i = 0; i < SYNC_STG; i++) begin
        sync_q[i] <= sync_d[i];
      end
      rdaddr_q <= rdaddr_d;
      rdptr_q  <= rdptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
    end
  end

`ifdef RD_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  always_comb underflow_d = underflow_q | (rdreq & empty_q);

  always_ff @(posedge rdclk) begin
    if (rst) underflow_q <= 1'b0;
    else     underflow_q <= underflow_d;
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

  assign rdptr        = rdptr_q;
  assign rdaddr       = rdaddr_q;
  assign empty_reg    = empty_q;
  assign rd_level     = level_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_checking_empty.sv
// Directed self-checking bench for checking_empty with default parameters (Addr=3, SYNC_STG=2, AE_THRESH=1).
module tb_checking_empty;

  logic       rdclk = 1'b0;
  logic       rst = 1'b1;
  logic       rdreq = 1'b0;
  logic [3:0] wrptr_in = 4'd0;
  logic [3:0] rdptr, rdaddr, rd_level;
  logic       empty_reg, almost_empty, underflow;

  int n_chk = 0;
  int n_err = 0;

`ifdef RD_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  checking_empty dut (
    .rdclk        (rdclk),
    .rst          (rst),
    .rdreq        (rdreq),
    .wrptr_in     (wrptr_in),
    .rdptr        (rdptr),
    .rdaddr       (rdaddr),
    .empty_reg    (empty_reg),
    .rd_level     (rd_level),
    .almost_empty (almost_empty),
    .underflow    (underflow)
  );

  always #5 rdclk = ~rdclk;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge rdclk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rdaddr"}, rdaddr, 0);
    chk({tag, ".rdptr"}, rdptr, 0);
    chk({tag, ".empty"}, empty_reg, 1);
    chk({tag, ".level"}, rd_level, 0);
    chk({tag, ".ae"}, almost_empty, 1);
    chk({tag, ".uf"}, underflow, 0);
  endtask

  logic [3:0] w;
  logic [3:0] r;

  initial begin
    // 1: reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk_reset("rst");

    // 2: one entry, latency of SYNC_STG+1 edges, then a single read
    wrptr_in = gray(4'd1);
    tick();
    chk("lat1.empty", empty_reg, 1);
    tick();
    chk("lat2.empty", empty_reg, 1);
    tick();
    chk("lat3.empty", empty_reg, 0);
    chk("lat3.level", rd_level, 1);
    chk("lat3.ae", almost_empty, 1);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("rd1.rdaddr", rdaddr, 1);
    chk("rd1.rdptr", rdptr, 4'b0001);
    chk("rd1.empty", empty_reg, 1);
    chk("rd1.level", rd_level, 0);

    // 3: full FIFO drained back-to-back
    rst = 1'b1;
    wrptr_in = 4'd0;
    tick();
    rst = 1'b0;
    wrptr_in = 4'b1100;
    tick(3);
    chk("full.level", rd_level, 8);
    chk("full.ae", almost_empty, 0);
    chk("full.empty", empty_reg, 0);
    rdreq = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) rdreq = 1'b0;
      chk($sformatf("drain%0d.level", k), rd_level, 8 - k);
      chk($sformatf("drain%0d.ae", k), almost_empty, (8 - k) <= 1);
      chk($sformatf("drain%0d.empty", k), empty_reg, k == 8);
    end
    chk("drain.rdaddr", rdaddr, 8);
    chk("drain.rdptr", rdptr, 4'b1100);

    // 4: 16 write/read pairs across the pointer wrap
    w = 4'd8;
    r = 4'd8;
    for (int k = 0; k < 16; k++) begin
      w = w + 4'd1;
      wrptr_in = gray(w);
      tick(3);
      chk($sformatf("wrap%0d.level", k), rd_level, 1);
      chk($sformatf("wrap%0d.empty0", k), empty_reg, 0);
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      r = r + 4'd1;
      chk($sformatf("wrap%0d.rdaddr", k), rdaddr, r);
      chk($sformatf("wrap%0d.rdptr", k), rdptr, gray(r));
      chk($sformatf("wrap%0d.empty1", k), empty_reg, 1);
      chk($sformatf("wrap%0d.lvl0", k), rd_level, 0);
    end

    // 5: reads while empty are ignored
    rdreq = 1'b1;
    tick();
    chk("uf1.uf", underflow, UF_EXP);
    tick(2);
    rdreq = 1'b0;
    chk("uf.rdaddr", rdaddr, 8);
    chk("uf.rdptr", rdptr, gray(4'd8));
    chk("uf.empty", empty_reg, 1);
    chk("uf.level", rd_level, 0);
    tick(2);
    chk("uf.sticky", underflow, UF_EXP);

    // 6: reset with level 5 and a pending read
    wrptr_in = gray(4'd13);
    tick(3);
    chk("pre6.level", rd_level, 5);
    chk("pre6.ae", almost_empty, 0);
    rdreq = 1'b1;
    rst = 1'b1;
    tick();
    chk_reset("rst6");
    rst = 1'b0;
    rdreq = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
